// File: rtl/tally_pkg.sv
// Shared types and sizing helpers for the row-tally frame sequencer.
// Optional threshold counting is enabled by the TALLY_THRESH_EN macro (see tally_2d_sequencer).
package tally_pkg;

    localparam int ROW_W = 12;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } tally_state_e;

    // Width needed to hold the largest possible frame total without wrapping.
    function automatic int tot_w(input int rows);
        return $clog2(rows * ROW_W + 1);
    endfunction

endpackage

// File: rtl/row_tally.sv
// Combinational 12-bit row popcount feeding the frame accumulator.
module row_tally
    import tally_pkg::*;
(
    input  logic [ROW_W-1:0] i_row,
    output logic [CNT_W-1:0] o_cnt
);

    // Sum the set bits of the row.
    always_comb begin
        o_cnt = {CNT_W{1'b0}};
        for (int i = 0; i < ROW_W; i++) begin
            o_cnt = o_cnt + {{(CNT_W-1){1'b0}}, i_row[i]};
        end
    end

endmodule

// File: rtl/tally_2d_sequencer.sv
// Frame controller: streams ROWS rows through row_tally, accumulating the total and the densest row.
// Define TALLY_THRESH_EN to add i_thresh / o_over_rows (rows whose count reaches the threshold).
module tally_2d_sequencer
    import tally_pkg::*;
#(
    parameter  int ROWS  = 12,
    localparam int TOT_W = tot_w(ROWS),
    localparam int IDX_W = $clog2(ROWS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [ROW_W-1:0] i_row_in,
    output logic             o_busy,
    output logic             o_done_valid,
    input  logic             i_done_ready,
`ifdef TALLY_THRESH_EN
    input  logic [CNT_W-1:0] i_thresh,
    output logic [IDX_W:0]   o_over_rows,
`endif
    output logic [TOT_W-1:0] o_total,
    output logic [CNT_W-1:0] o_max_count,
    output logic [IDX_W-1:0] o_max_index
);

    // One spare counter bit lets the count reach ROWS without wrapping when ROWS is a power of two.
    localparam logic [IDX_W:0] LAST_ROW = (IDX_W+1)'(ROWS - 1);

    tally_state_e     r_state;
    tally_state_e     w_state_nxt;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done_valid;
    logic [IDX_W:0]   r_row_cnt;
    logic [TOT_W-1:0] r_total;
    logic [CNT_W-1:0] r_max_count;
    logic [IDX_W-1:0] r_max_index;
    logic [CNT_W-1:0] w_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_start_ok;

    row_tally u_row_tally (
        .i_row (i_row_in),
        .o_cnt (w_cnt)
    );

    assign w_accept   = r_in_ready & i_in_valid;
    assign w_last     = w_accept & (r_row_cnt == LAST_ROW);
    assign w_start_ok = (r_state == IDLE) & i_start;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) w_state_nxt = ACCUM;
                else         w_state_nxt = IDLE;
            end
            ACCUM: begin
                if (w_last) w_state_nxt = DONE;
                else        w_state_nxt = ACCUM;
            end
            DONE: begin
                if (r_done_valid && i_done_ready) w_state_nxt = IDLE;
                else                              w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_in_ready   <= (w_state_nxt == ACCUM);
            r_busy       <= (w_state_nxt != IDLE);
            r_done_valid <= (w_state_nxt == DONE);
        end
    end

    // Accumulator and max tracker; strict compare keeps the lowest index on ties.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_row_cnt   <= {(IDX_W+1){1'b0}};
            r_total     <= {TOT_W{1'b0}};
            r_max_count <= {CNT_W{1'b0}};
            r_max_index <= {IDX_W{1'b0}};
        end else if (w_start_ok) begin
            r_row_cnt   <= {(IDX_W+1){1'b0}};
            r_total     <= {TOT_W{1'b0}};
            r_max_count <= {CNT_W{1'b0}};
            r_max_index <= {IDX_W{1'b0}};
        end else if (w_accept) begin
            r_row_cnt <= r_row_cnt + {{IDX_W{1'b0}}, 1'b1};
            r_total   <= r_total + TOT_W'(w_cnt);
            if (w_cnt > r_max_count) begin
                r_max_count <= w_cnt;
                r_max_index <= r_row_cnt[IDX_W-1:0];
            end
        end
    end

`ifdef TALLY_THRESH_EN
    logic [IDX_W:0] r_over_rows;

    // Count accepted rows whose popcount reaches the per-row threshold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_over_rows <= {(IDX_W+1){1'b0}};
        end else if (w_start_ok) begin
            r_over_rows <= {(IDX_W+1){1'b0}};
        end else if (w_accept && (w_cnt >= i_thresh)) begin
            r_over_rows <= r_over_rows + {{IDX_W{1'b0}}, 1'b1};
        end
    end

    assign o_over_rows = r_over_rows;
`endif

    assign o_in_ready   = r_in_ready;
    assign o_busy       = r_busy;
    assign o_done_valid = r_done_valid;
    assign o_total      = r_total;
    assign o_max_count  = r_max_count;
    assign o_max_index  = r_max_index;

endmodule

// File: tb/tb_tally_2d_sequencer.sv
// Randomized self-checking bench for tally_2d_sequencer against a frame-level reference model.
module tb_tally_2d_sequencer;
    import tally_pkg::*;

    localparam int ROWS  = 12;
    localparam int TOT_W = tot_w(ROWS);
    localparam int IDX_W = $clog2(ROWS);

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic             i_in_valid;
    logic             o_in_ready;
    logic [ROW_W-1:0] i_row_in;
    logic             o_busy;
    logic             o_done_valid;
    logic             i_done_ready;
`ifdef TALLY_THRESH_EN
    logic [CNT_W-1:0] i_thresh;
    logic [IDX_W:0]   o_over_rows;
`endif
    logic [TOT_W-1:0] o_total;
    logic [CNT_W-1:0] o_max_count;
    logic [IDX_W-1:0] o_max_index;

    tally_2d_sequencer #(.ROWS(ROWS)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_row_in     (i_row_in),
        .o_busy       (o_busy),
        .o_done_valid (o_done_valid),
        .i_done_ready (i_done_ready),
`ifdef TALLY_THRESH_EN
        .i_thresh     (i_thresh),
        .o_over_rows  (o_over_rows),
`endif
        .o_total      (o_total),
        .o_max_count  (o_max_count),
        .o_max_index  (o_max_index)
    );

    always #5 i_clk = ~i_clk;

    logic [ROW_W-1:0] frame_rows [ROWS];
    logic [CNT_W-1:0] frame_th   [ROWS];
    int n_vec = 0;
    int n_err = 0;
    int exp_total, exp_max, exp_idx, exp_over;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference: frame statistics straight from the row list.
    task automatic model();
        exp_total = 0; exp_max = 0; exp_idx = 0; exp_over = 0;
        for (int i = 0; i < ROWS; i++) begin
            int c;
            c = $countones(frame_rows[i]);
            exp_total += c;
            if (c > exp_max) begin exp_max = c; exp_idx = i; end
            if (c >= int'(frame_th[i])) exp_over++;
        end
    endtask

    task automatic chk_results(input string tag);
        chk({tag, "_total"}, 32'(o_total), exp_total);
        chk({tag, "_max"},   32'(o_max_count), exp_max);
        chk({tag, "_idx"},   32'(o_max_index), exp_idx);
`ifdef TALLY_THRESH_EN
        chk({tag, "_over"},  32'(o_over_rows), exp_over);
`endif
    endtask

    task automatic run_frame(input string tag, input int gap_pct, input int hold_cycles);
        int idx = 0;
        int cyc = 0;
        logic ready_now;
        model();
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        chk({tag, "_busy_start"}, 32'(o_busy), 1);
        chk({tag, "_ready_start"}, 32'(o_in_ready), 1);
        while (idx < ROWS && cyc < 500) begin
            i_in_valid = ($urandom_range(99) >= gap_pct);
            i_row_in   = i_in_valid ? frame_rows[idx] : ROW_W'($urandom);
`ifdef TALLY_THRESH_EN
            i_thresh   = i_in_valid ? frame_th[idx] : CNT_W'($urandom);
`endif
            ready_now  = o_in_ready;
            @(negedge i_clk);
            if (i_in_valid && ready_now) idx++;
            cyc++;
        end
        i_in_valid = 1'b0;
        if (cyc >= 500) chk({tag, "_frame_timeout"}, idx, ROWS);
        chk({tag, "_done_valid"}, 32'(o_done_valid), 1);
        chk({tag, "_ready_drop"}, 32'(o_in_ready), 0);
        chk_results(tag);
        for (int k = 0; k < hold_cycles; k++) begin
            i_in_valid = $urandom_range(1);
            i_start    = $urandom_range(1);
            i_row_in   = 12'hFFF;
            @(negedge i_clk);
            chk({tag, "_hold_done"}, 32'(o_done_valid), 1);
            chk({tag, "_hold_total"}, 32'(o_total), exp_total);
        end
        i_in_valid   = 1'b0;
        i_start      = 1'b1;
        i_done_ready = 1'b1;
        @(negedge i_clk);
        i_start      = 1'b0;
        i_done_ready = 1'b0;
        chk({tag, "_done_clear"}, 32'(o_done_valid), 0);
        @(negedge i_clk);
        chk({tag, "_idle_busy"}, 32'(o_busy), 0);
        chk_results({tag, "_idle"});
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_in_valid = 1'b0; i_row_in = 12'h000; i_done_ready = 1'b0;
`ifdef TALLY_THRESH_EN
        i_thresh = 4'd0;
`endif
        repeat (3) @(negedge i_clk);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_ready", 32'(o_in_ready), 0);
        chk("rst_done", 32'(o_done_valid), 0);
        chk("rst_total", 32'(o_total), 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        i_done_ready = 1'b1;
        @(negedge i_clk);
        i_done_ready = 1'b0;
        chk("idle_ready_ignored", 32'(o_busy), 0);

        for (int i = 0; i < ROWS; i++) begin frame_rows[i] = 12'hFFF; frame_th[i] = 4'd0; end
        run_frame("all_ones", 0, 2);

        for (int i = 0; i < ROWS; i++) begin
            frame_rows[i] = ROW_W'((32'd1 << i) - 32'd1);
            frame_th[i]   = 4'd6;
        end
        run_frame("ramp", 0, 1);

        for (int i = 0; i < ROWS; i++) begin frame_rows[i] = 12'h003; frame_th[i] = 4'd3; end
        frame_rows[5] = 12'h00F;
        frame_rows[8] = 12'h0F0;
        run_frame("tie", 0, 1);

        run_frame("sparse_hold", 60, 10);

        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        i_in_valid = 1'b1; i_row_in = 12'hFFF;
        repeat (6) @(negedge i_clk);
        i_in_valid = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(o_busy), 0);
        chk("midrst_ready", 32'(o_in_ready), 0);
        chk("midrst_total", 32'(o_total), 0);
        chk("midrst_max", 32'(o_max_count), 0);
        chk("midrst_idx", 32'(o_max_index), 0);
`ifdef TALLY_THRESH_EN
        chk("midrst_over", 32'(o_over_rows), 0);
`endif
        @(negedge i_clk); i_rst = 1'b0;
        for (int i = 0; i < ROWS; i++) begin frame_rows[i] = 12'h000; frame_th[i] = 4'd1; end
        run_frame("zeros", 0, 1);

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < ROWS; i++) begin
                frame_rows[i] = ROW_W'($urandom) & ROW_W'($urandom);
                frame_th[i]   = CNT_W'($urandom_range(12));
            end
            run_frame("rand", $urandom_range(70), $urandom_range(4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
